// File: rtl/modsq_carry_normalizer.sv
// Carry normalizer for the modular-squaring datapath.
// Captures one redundant-form squaring result (one BIT_LEN coefficient per
// 32-bit lane), ripples the carries one coefficient per clock, and holds the
// canonical WORD_LEN-per-word integer plus final carry for a ready/valid
// consumer.
module modsq_carry_normalizer #(
    parameter int MOD_LEN               = 1024,
    parameter int WORD_LEN              = 16,
    parameter int BIT_LEN               = 17,
    parameter int REDUNDANT_ELEMENTS    = 2,
    parameter int NONREDUNDANT_ELEMENTS = MOD_LEN / WORD_LEN,
    parameter int NUM_ELEMENTS          = NONREDUNDANT_ELEMENTS + REDUNDANT_ELEMENTS,
    parameter int SQ_OUT_BITS           = NUM_ELEMENTS * WORD_LEN * 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic [SQ_OUT_BITS-1:0]           sq_in_packed,
    output logic                             in_ready,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_ELEMENTS*WORD_LEN-1:0] result,
    output logic [1:0]                       carry_out,
    output logic                             overrun
);

    localparam int LANE_W = 32;
    localparam int IDX_W  = $clog2(NUM_ELEMENTS);
    localparam int SUM_W  = BIT_LEN + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMENTS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PROP = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Coefficient + incoming carry; the sum is at most 2^17-1 + 2, so it
    // always fits in BIT_LEN+1 bits and the carry above WORD_LEN fits in 2.
    function automatic logic [SUM_W-1:0] carry_add(input logic [BIT_LEN-1:0] coef,
                                                   input logic [1:0]         carry);
        return SUM_W'(coef) + SUM_W'(carry);
    endfunction

    logic [BIT_LEN-1:0]  coef_in [NUM_ELEMENTS];
    logic [BIT_LEN-1:0]  coef_p0 [NUM_ELEMENTS];
    logic [WORD_LEN-1:0] result_p1 [NUM_ELEMENTS];
    logic [1:0]          carry_p1;
    logic [IDX_W-1:0]    idx;
    logic [SUM_W-1:0]    sum_p0;
    logic                accept;

    // Lane unpacking: only the low BIT_LEN bits of each lane carry the
    // coefficient; the rest of the lane is deliberately discarded.
    for (genvar j = 0; j < NUM_ELEMENTS; j++) begin : g_lane
        logic unused_hi;
        assign coef_in[j] = sq_in_packed[j*LANE_W +: BIT_LEN];
        assign unused_hi  = ^sq_in_packed[j*LANE_W+BIT_LEN +: LANE_W-BIT_LEN];
        assign result[j*WORD_LEN +: WORD_LEN] = result_p1[j];
    end

    assign accept = in_valid && in_ready;
    assign sum_p0 = carry_add(coef_p0[idx], carry_p1);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: capture, ripple through every coefficient, hold
    // until the consumer takes the result.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (in_valid)               state_next = S_PROP;
            S_PROP: if (idx == LAST_IDX)        state_next = S_HOLD;
            S_HOLD: if (out_valid && out_ready) state_next = S_IDLE;
            default:                            state_next = S_IDLE;
        endcase
    end

    // Output logic: in_ready is forced low for as long as reset is held.
    always_comb begin
        in_ready = reset && (state == S_IDLE);
    end

    // Control registers: index, running carry, valid, final carry, overrun.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx       <= '0;
            carry_p1  <= '0;
            out_valid <= 1'b0;
            carry_out <= '0;
            overrun   <= 1'b0;
        end else begin
            if (in_valid && !in_ready) begin
                overrun <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        idx      <= '0;
                        carry_p1 <= '0;
                    end
                end
                S_PROP: begin
                    idx      <= idx + 1'b1;
                    carry_p1 <= sum_p0[WORD_LEN +: 2];
                    if (idx == LAST_IDX) begin
                        carry_out <= sum_p0[WORD_LEN +: 2];
                    end
                end
                S_HOLD: begin
                    // out_valid rises one cycle into HOLD, so the handshake
                    // can only complete once the consumer has seen it high.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---- stage 0: coefficient capture ----
    // Coefficient capture on an accepted input.
    always_ff @(posedge clk) begin
        if (accept) begin
            coef_p0 <= coef_in;
        end
    end

    // ---- stage 1: canonical word write-back ----
    // Canonical word write-back, one word per PROP cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NUM_ELEMENTS; k++) begin
                result_p1[k] <= '0;
            end
        end else if (state == S_PROP) begin
            result_p1[idx] <= sum_p0[WORD_LEN-1:0];
        end
    end

endmodule
